// File: rtl/mc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_arb_pkg
// Description : Shared types and constants for the memory-controller pad-bus
//               arbiter (mc_bus_arb) and its round-robin picker.
//               Contents:
//                 arb_state_e - arbiter FSM state encoding
//                 TURN_CYC    - bus turnaround length in cycles
//                 c_STAT_W    - width of the optional statistics counters
//                 rr_wrap()   - modular wrap for round-robin index math
// Revision    : 1.0 - initial release
// ============================================================================
package mc_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GRANT    = 3'd1,
        TURN_IN  = 3'd2,
        EXT_GNT  = 3'd3,
        TURN_OUT = 3'd4
    } arb_state_e;

    // Cycles spent with every pad tristated on each side of an external grant.
    localparam int TURN_CYC = 1;

    localparam int c_STAT_W = 16;

    // Wrap an index that may have overrun the requester count by less than n.
    function automatic int rr_wrap(input int a, input int n);
        return (a >= n) ? (a - n) : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : mc_rr_picker
// Description : Combinational round-robin selector. Returns the first set
//               request at or after the pointer, wrapping past the top.
// Ports       : i_req     [NUM_REQ]  request vector
//               i_ptr     [PTR_W]    search start index (< NUM_REQ)
//               o_onehot  [NUM_REQ]  one-hot winner (zero when none)
//               o_idx     [PTR_W]    winner index (zero when none)
//               o_valid              at least one request set
// Revision    : 1.0 - initial release
// ============================================================================
module mc_rr_picker
    import mc_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_onehot,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_valid
);

    localparam int c_PTR_W = $clog2(NUM_REQ);

    logic [c_PTR_W-1:0] w_cand;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = c_PTR_W'(rr_wrap(int'(i_ptr) + k, NUM_REQ));
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : mc_bus_arb
// Description : Owner of the memory pad bus. Round-robin arbitration between
//               NUM_REQ internal requesters plus the external bus-request /
//               bus-grant handshake with a tristate turnaround on both sides
//               of every external tenure.
// Ports       : mc_clk_i, mc_rst_i (sync, active high)
//               req_i [NUM_REQ]   level requests, held until granted
//               done_i [NUM_REQ]  owner finished one transaction (pulse)
//               gnt_o [NUM_REQ]   registered one-hot grant
//               gnt_id_o          current owner index
//               mc_br_pad_i       external bus request (asynchronous)
//               mc_bg_pad_o       external bus grant (registered)
//               pad_oe_o          1 = controller drives the pads
//               busy_o            FSM not in IDLE
// Config      : MC_ARB_STATS_EN adds stats_clr_i, ext_gnt_cnt_o, wait_max_o.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_bus_arb
    import mc_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                        mc_clk_i,
    input  logic                        mc_rst_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          done_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [$clog2(NUM_REQ)-1:0]  gnt_id_o,
    input  logic                        mc_br_pad_i,
    output logic                        mc_bg_pad_o,
    output logic                        pad_oe_o,
    output logic                        busy_o
`ifdef MC_ARB_STATS_EN
    ,
    input  logic                        stats_clr_i,
    output logic [c_STAT_W-1:0]         ext_gnt_cnt_o,
    output logic [c_STAT_W-1:0]         wait_max_o
`endif
);

    localparam int c_PTR_W  = $clog2(NUM_REQ);
    localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int c_TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

    localparam logic [c_PTR_W-1:0]  c_PTR_LAST  = c_PTR_W'(NUM_REQ - 1);
    localparam logic [c_HOLD_W:0]   c_HOLD_LIM  = (c_HOLD_W + 1)'(MAX_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_SAT  = c_HOLD_W'(MAX_HOLD);
    localparam logic [c_TURN_W-1:0] c_TURN_LAST = c_TURN_W'(TURN_CYC - 1);
    localparam logic [NUM_REQ-1:0]  c_ONE       = NUM_REQ'(1);

    // ------------------------------------------------------------------
    // External request synchronizer
    // ------------------------------------------------------------------
    logic r_br_meta;
    logic r_br_s;

    // ------------------------------------------------------------------
    // Arbiter state
    // ------------------------------------------------------------------
    arb_state_e          r_state;
    arb_state_e          w_next;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [c_PTR_W-1:0]  w_ptr_nxt;
    logic [c_PTR_W-1:0]  r_owner;
    logic [c_PTR_W-1:0]  w_owner_nxt;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic [c_HOLD_W:0]   w_hold_inc;
    logic [c_TURN_W-1:0] r_turn;
    logic [c_TURN_W-1:0] w_turn_nxt;

    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [NUM_REQ-1:0]  w_owner_oh;
    logic [NUM_REQ-1:0]  w_others;
    logic                r_bg;
    logic                r_oe;

    logic [NUM_REQ-1:0]  w_pick_oh;
    logic [c_PTR_W-1:0]  w_pick_idx;
    logic                w_pick_vld;

    mc_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req    (req_i),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_vld)
    );

    assign w_owner_oh = c_ONE << r_owner;
    assign w_others   = req_i & ~w_owner_oh;
    // One bit wider than the counter so the MAX_HOLD compare cannot wrap.
    assign w_hold_inc = {1'b0, r_hold} + (c_HOLD_W + 1)'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold;
        w_turn_nxt  = '0;

        case (r_state)
            IDLE: begin
                // The external master always wins an idle bus.
                if (r_br_s) begin
                    w_next = TURN_IN;
                end else if (w_pick_vld) begin
                    w_next      = GRANT;
                    w_owner_nxt = w_pick_idx;
                    w_ptr_nxt   = (w_pick_idx == c_PTR_LAST) ? '0
                                : w_pick_idx + c_PTR_W'(1);
                    w_hold_nxt  = '0;
                end
            end

            GRANT: begin
                if (done_i[r_owner]) begin
                    if (r_hold != c_HOLD_SAT) begin
                        w_hold_nxt = w_hold_inc[c_HOLD_W-1:0];
                    end
                    // A pending external request only takes effect at a
                    // transaction boundary; it never cuts one short.
                    if (req_i[r_owner] && !r_br_s &&
                        ((w_hold_inc < c_HOLD_LIM) || (w_others == '0))) begin
                        w_next = GRANT;
                    end else begin
                        w_next = r_br_s ? TURN_IN : IDLE;
                    end
                end else if (!req_i[r_owner]) begin
                    w_next = IDLE;
                end
            end

            TURN_IN: begin
                if (r_turn == c_TURN_LAST) begin
                    // A request withdrawn during turnaround skips the grant.
                    w_next = r_br_s ? EXT_GNT : TURN_OUT;
                end else begin
                    w_turn_nxt = r_turn + c_TURN_W'(1);
                end
            end

            EXT_GNT: begin
                if (!r_br_s) begin
                    w_next = TURN_OUT;
                end
            end

            TURN_OUT: begin
                if (r_turn == c_TURN_LAST) begin
                    w_next = IDLE;
                end else begin
                    w_turn_nxt = r_turn + c_TURN_W'(1);
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_gnt_nxt = (w_next == GRANT) ? (c_ONE << w_owner_nxt) : '0;

    // ------------------------------------------------------------------
    // State and output registers; outputs decode the next state so they
    // change on the same edge as the state itself.
    // ------------------------------------------------------------------
    always_ff @(posedge mc_clk_i) begin
        if (mc_rst_i) begin
            r_br_meta <= 1'b0;
            r_br_s    <= 1'b0;
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_hold    <= '0;
            r_turn    <= '0;
            r_gnt     <= '0;
            r_bg      <= 1'b0;
            r_oe      <= 1'b0;
        end else begin
            r_br_meta <= mc_br_pad_i;
            r_br_s    <= r_br_meta;
            r_state   <= w_next;
            r_ptr     <= w_ptr_nxt;
            r_owner   <= w_owner_nxt;
            r_hold    <= w_hold_nxt;
            r_turn    <= w_turn_nxt;
            r_gnt     <= w_gnt_nxt;
            r_bg      <= (w_next == EXT_GNT);
            r_oe      <= (w_next == IDLE) || (w_next == GRANT);
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_id_o    = r_owner;
    assign mc_bg_pad_o = r_bg;
    assign pad_oe_o    = r_oe;
    assign busy_o      = (r_state != IDLE);

`ifdef MC_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: external grant count and worst internal wait time.
    // ------------------------------------------------------------------
    localparam logic [c_STAT_W-1:0] c_STAT_MAX = '1;

    logic [c_STAT_W-1:0] r_ext_cnt;
    logic [c_STAT_W-1:0] r_wait_max;
    logic [c_STAT_W-1:0] r_wait [NUM_REQ];
    logic [c_STAT_W-1:0] w_wait_peak;
    logic                w_ext_entry;

    assign w_ext_entry = (r_state == TURN_IN) && (w_next == EXT_GNT);

    always_comb begin
        w_wait_peak = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_wait[i] > w_wait_peak) begin
                w_wait_peak = r_wait[i];
            end
        end
    end

    always_ff @(posedge mc_clk_i) begin
        if (mc_rst_i) begin
            r_ext_cnt  <= '0;
            r_wait_max <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                r_wait[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_i[i] && !r_gnt[i]) begin
                    if (r_wait[i] != c_STAT_MAX) begin
                        r_wait[i] <= r_wait[i] + c_STAT_W'(1);
                    end
                end else begin
                    r_wait[i] <= '0;
                end
            end
            if (stats_clr_i) begin
                r_ext_cnt  <= '0;
                r_wait_max <= '0;
            end else begin
                if (w_ext_entry && (r_ext_cnt != c_STAT_MAX)) begin
                    r_ext_cnt <= r_ext_cnt + c_STAT_W'(1);
                end
                if (w_wait_peak > r_wait_max) begin
                    r_wait_max <= w_wait_peak;
                end
            end
        end
    end

    assign ext_gnt_cnt_o = r_ext_cnt;
    assign wait_max_o    = r_wait_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_bus_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_bus_arb
// Description : Self-checking bench for mc_bus_arb. Expected grant owners are
//               queued as stimulus is applied and popped whenever a new grant
//               appears; scenario tasks check timing and pad control inline.
//               Build with MC_ARB_STATS_EN to include the statistics test.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_bus_arb;

    localparam int NUM_REQ  = 4;
    localparam int MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic       br = 1'b0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       bg;
    logic       oe;
    logic       busy;
`ifdef MC_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] ext_cnt;
    logic [15:0] wait_max;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    mc_bus_arb #(
        .NUM_REQ  (NUM_REQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .mc_clk_i    (clk),
        .mc_rst_i    (rst),
        .req_i       (req),
        .done_i      (done),
        .gnt_o       (gnt),
        .gnt_id_o    (gnt_id),
        .mc_br_pad_i (br),
        .mc_bg_pad_o (bg),
        .pad_oe_o    (oe),
        .busy_o      (busy)
`ifdef MC_ARB_STATS_EN
        ,
        .stats_clr_i   (stats_clr),
        .ext_gnt_cnt_o (ext_cnt),
        .wait_max_o    (wait_max)
`endif
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Invariant monitor and grant scoreboard
    // ------------------------------------------------------------------
    logic [3:0] req_at_edge = '0;
    logic [3:0] gnt_prev    = '0;
    int         sb_exp;

    always @(posedge clk) req_at_edge <= req;

    always @(negedge clk) begin
        if (!rst) begin
            n_checks++;
            if (bg && oe) begin
                n_errors++; $display("FAIL inv_bg_oe: bg=%b oe=%b, required not both 1", bg, oe);
            end
            n_checks++;
            if (bg && (gnt != 4'b0)) begin
                n_errors++; $display("FAIL inv_bg_gnt: bg=%b gnt=%b, required not both set", bg, gnt);
            end
            n_checks++;
            if ((gnt & (gnt - 4'd1)) != 4'b0) begin
                n_errors++; $display("FAIL inv_onehot: gnt=%b, required one-hot or zero", gnt);
            end
            n_checks++;
            if ((gnt & ~req_at_edge) != 4'b0) begin
                n_errors++; $display("FAIL inv_gnt_req: gnt=%b req=%b, required no grant without req", gnt, req_at_edge);
            end
            if ((gnt != 4'b0) && (gnt != gnt_prev)) begin
                n_checks++;
                if (gnt_prev != 4'b0) begin
                    n_errors++; $display("FAIL handoff_idle: gnt %b -> %b, required an idle cycle", gnt_prev, gnt);
                end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL sb_unexpected: gnt=%b, required no grant", gnt);
                end else begin
                    sb_exp = exp_q.pop_front();
                    if (gnt !== (4'b0001 << sb_exp)) begin
                        n_errors++; $display("FAIL sb_order: gnt=%b, required %b", gnt, 4'b0001 << sb_exp);
                    end
                end
            end
        end
        gnt_prev <= gnt;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Helpers (stimulus only)
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        br   = 1'b0;
        cyc(3);
        rst  = 1'b0;
        cyc(1);
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1; req = '0; done = '0; br = 1'b0;
        cyc(3);
        n_checks++; if (gnt !== 4'b0)   begin n_errors++; $display("FAIL rst_gnt: got %b want 0000", gnt); end
        n_checks++; if (gnt_id !== 2'd0) begin n_errors++; $display("FAIL rst_gnt_id: got %0d want 0", gnt_id); end
        n_checks++; if (bg !== 1'b0)    begin n_errors++; $display("FAIL rst_bg: got %b want 0", bg); end
        n_checks++; if (oe !== 1'b0)    begin n_errors++; $display("FAIL rst_oe: got %b want 0", oe); end
        n_checks++; if (busy !== 1'b0)  begin n_errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        rst = 1'b0;
        cyc(1);
        n_checks++; if (oe !== 1'b1)    begin n_errors++; $display("FAIL rst_oe_release: got %b want 1", oe); end
    endtask

    task automatic test_basic();
        do_reset();
        exp_q.push_back(0);
        exp_q.push_back(2);
        req = 4'b0101;
        cyc(1);
        n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("FAIL t1_first_gnt: got %b want 0001", gnt); end
        n_checks++; if (gnt_id !== 2'd0) begin n_errors++; $display("FAIL t1_first_id: got %0d want 0", gnt_id); end
        done = 4'b0001;
        cyc(1);
        n_checks++; if (gnt !== 4'b0001) begin n_errors++; $display("FAIL t1_keep: got %b want 0001", gnt); end
        done = 4'b0000;
        req  = 4'b0100;
        cyc(1);
        n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("FAIL t1_idle_gap: got %b want 0000", gnt); end
        n_checks++; if (busy !== 1'b0)   begin n_errors++; $display("FAIL t1_idle_busy: got %b want 0", busy); end
        cyc(1);
        n_checks++; if (gnt !== 4'b0100) begin n_errors++; $display("FAIL t1_second_gnt: got %b want 0100", gnt); end
        n_checks++; if (gnt_id !== 2'd2) begin n_errors++; $display("FAIL t1_second_id: got %0d want 2", gnt_id); end
        req = 4'b0000;
        cyc(2);
    endtask

    task automatic test_hold_alone();
        // A lone requester keeps the bus beyond MAX_HOLD transactions.
        do_reset();
        exp_q.push_back(0);
        req = 4'b0001;
        cyc(1);
        for (int i = 0; i < MAX_HOLD + 4; i++) begin
            n_checks++;
            if (gnt !== 4'b0001) begin
                n_errors++; $display("FAIL hold_alone_%0d: got %b want 0001", i, gnt);
            end
            done = 4'b0001;
            cyc(1);
        end
        done = 4'b0000;
        req  = 4'b0000;
        cyc(2);
        n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("FAIL hold_alone_release: got %b want 0000", gnt); end
    endtask

    task automatic test_round_robin();
        int runs[4];
        int nrun;
        int cnt;
        logic [3:0] g;
        logic [3:0] gp;
        do_reset();
        for (int i = 0; i < 5; i++) exp_q.push_back(i % 4);
        nrun = 0;
        cnt  = 0;
        gp   = '0;
        req  = 4'b1111;
        for (int c = 0; c < 80; c++) begin
            cyc(1);
            g = gnt;
            if (g != 4'b0) cnt++;
            if ((gp != 4'b0) && (g == 4'b0)) begin
                if (nrun < 4) runs[nrun] = cnt;
                nrun++;
                cnt = 0;
            end
            done = g;
            gp   = g;
            if ((nrun >= 4) && (g != 4'b0)) break;
        end
        req  = 4'b0000;
        done = 4'b0000;
        n_checks++; if (nrun != 4) begin n_errors++; $display("FAIL rr_runs: got %0d owner tenures want 4", nrun); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (runs[i] != MAX_HOLD) begin
                n_errors++; $display("FAIL rr_dones_%0d: got %0d want %0d", i, runs[i], MAX_HOLD);
            end
        end
        cyc(2);
    endtask

    task automatic test_ext_preempt();
        int k;
        do_reset();
        exp_q.push_back(1);
        req = 4'b0010;
        cyc(1);
        n_checks++; if (gnt !== 4'b0010) begin n_errors++; $display("FAIL t3_gnt: got %b want 0010", gnt); end
        br = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            n_checks++;
            if (gnt !== 4'b0010) begin n_errors++; $display("FAIL t3_held_%0d: got %b want 0010", i, gnt); end
        end
        done = 4'b0010;
        cyc(1);
        done = 4'b0000;
        req  = 4'b0000;
        n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("FAIL t3_turnin_gnt: got %b want 0000", gnt); end
        n_checks++; if (oe !== 1'b0)     begin n_errors++; $display("FAIL t3_turnin_oe: got %b want 0", oe); end
        n_checks++; if (bg !== 1'b0)     begin n_errors++; $display("FAIL t3_turnin_bg: got %b want 0", bg); end
        cyc(1);
        n_checks++; if (bg !== 1'b1)     begin n_errors++; $display("FAIL t3_bg: got %b want 1", bg); end
        cyc(3);
        br = 1'b0;
        k  = 0;
        while (bg && (k < 8)) begin
            cyc(1);
            k++;
        end
        n_checks++; if (bg !== 1'b0) begin n_errors++; $display("FAIL t3_bg_drop: got %b want 0 within 8 cycles", bg); end
        n_checks++; if (oe !== 1'b0) begin n_errors++; $display("FAIL t3_turnout_oe: got %b want 0", oe); end
        cyc(1);
        n_checks++; if (oe !== 1'b1) begin n_errors++; $display("FAIL t3_oe_back: got %b want 1", oe); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL t3_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_br_glitch();
        logic bg_seen;
        logic oe_low_seen;
        do_reset();
        bg_seen     = 1'b0;
        oe_low_seen = 1'b0;
        br = 1'b1;
        cyc(1);
        br = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            if (bg) bg_seen = 1'b1;
            if (!oe) oe_low_seen = 1'b1;
        end
        n_checks++; if (bg_seen !== 1'b0)     begin n_errors++; $display("FAIL t4_bg_pulse: got %b want 0", bg_seen); end
        n_checks++; if (oe_low_seen !== 1'b1) begin n_errors++; $display("FAIL t4_turnaround: got oe-low=%b want 1", oe_low_seen); end
        n_checks++; if (oe !== 1'b1)          begin n_errors++; $display("FAIL t4_oe_end: got %b want 1", oe); end
    endtask

    task automatic test_reset_ext();
        int k;
        do_reset();
        br = 1'b1;
        k  = 0;
        while (!bg && (k < 10)) begin
            cyc(1);
            k++;
        end
        n_checks++; if (bg !== 1'b1) begin n_errors++; $display("FAIL t5_reach_ext: got bg=%b want 1 within 10 cycles", bg); end
        rst = 1'b1;
        br  = 1'b0;
        cyc(1);
        n_checks++; if (bg !== 1'b0)     begin n_errors++; $display("FAIL t5_rst_bg: got %b want 0", bg); end
        n_checks++; if (gnt !== 4'b0000) begin n_errors++; $display("FAIL t5_rst_gnt: got %b want 0000", gnt); end
        n_checks++; if (oe !== 1'b0)     begin n_errors++; $display("FAIL t5_rst_oe: got %b want 0", oe); end
        rst = 1'b0;
        cyc(1);
        n_checks++; if (oe !== 1'b1)     begin n_errors++; $display("FAIL t5_oe_release: got %b want 1", oe); end
    endtask

`ifdef MC_ARB_STATS_EN
    task automatic test_stats();
        int k;
        do_reset();
        n_checks++; if (ext_cnt !== 16'd0)  begin n_errors++; $display("FAIL t6_rst_cnt: got %0d want 0", ext_cnt); end
        n_checks++; if (wait_max !== 16'd0) begin n_errors++; $display("FAIL t6_rst_wait: got %0d want 0", wait_max); end
        for (int n = 0; n < 3; n++) begin
            br = 1'b1;
            k  = 0;
            while (!bg && (k < 10)) begin cyc(1); k++; end
            br = 1'b0;
            k  = 0;
            while (!oe && (k < 10)) begin cyc(1); k++; end
        end
        n_checks++; if (ext_cnt !== 16'd3) begin n_errors++; $display("FAIL t6_cnt3: got %0d want 3", ext_cnt); end
        br = 1'b1;
        k  = 0;
        while (!(busy && !oe && !bg) && (k < 10)) begin cyc(1); k++; end
        stats_clr = 1'b1;
        cyc(1);
        stats_clr = 1'b0;
        n_checks++; if (bg !== 1'b1)       begin n_errors++; $display("FAIL t6_fourth_bg: got %b want 1", bg); end
        n_checks++; if (ext_cnt !== 16'd0) begin n_errors++; $display("FAIL t6_clr_wins: got %0d want 0", ext_cnt); end
        br = 1'b0;
        k  = 0;
        while (!oe && (k < 10)) begin cyc(1); k++; end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_hold_alone();
        test_round_robin();
        test_ext_preempt();
        test_br_glitch();
        test_reset_ext();
`ifdef MC_ARB_STATS_EN
        test_stats();
`endif
        cyc(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL sb_leftover: got %0d unmatched grants want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
